// File: rtl/vga_rx_pkg.sv
// Shared types and helpers for the VGA receive monitor: FSM state type,
// coordinate width, and sync leading-edge detection.
package vga_rx_pkg;

   localparam int COORD_W = 12;
   localparam logic [COORD_W-1:0] COORD_MAX = '1;

   // {previous sample asserted, current sample asserted} pattern of a leading edge
   localparam logic [1:0] EDGE_LEAD = 2'b01;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } rx_state_t;

   function automatic logic lead_edge(input logic prev, input logic cur, input logic pol);
      return {prev == pol, cur == pol} == EDGE_LEAD;
   endfunction

   function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v, input logic en);
      return (en && (v != COORD_MAX)) ? v + 12'd1 : v;
   endfunction

endpackage

// File: rtl/vga_rx_bbox.sv
// Running bounding box of matching pixels within the current frame.
// A hit on the frame-start cycle already belongs to the new frame.
module vga_rx_bbox
   import vga_rx_pkg::*;
(
   input  logic               pix_clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic               hit,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [COORD_W-1:0] x0,
   output logic [COORD_W-1:0] y0,
   output logic [COORD_W-1:0] x1,
   output logic [COORD_W-1:0] y1,
   output logic               found
);

   logic first_hit;
   assign first_hit = hit && (frame_start || !found);

   // first match of a frame seeds all four edges, later matches widen them
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         x0    <= '0;
         y0    <= '0;
         x1    <= '0;
         y1    <= '0;
         found <= 1'b0;
      end else if (first_hit) begin
         x0    <= x;
         y0    <= y;
         x1    <= x;
         y1    <= y;
         found <= 1'b1;
      end else if (hit) begin
         if (x < x0) x0 <= x;
         if (y < y0) y0 <= y;
         if (x > x1) x1 <= x;
         if (y > y1) y1 <= y;
      end else if (frame_start) begin
         found <= 1'b0;
      end
   end

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: measures line/frame timing, tracks the bounding box of
// a chosen colour and locks once timing matches the expected resolution.
// Optional VGA_RX_CHECKSUM_EN adds a per-frame sum of active pixels (frame_sum).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_SEARCH  | waiting for first vsync edge; partial frame discarded
// ST_MEASURE | publishing frames, timing not yet stable/expected
// ST_LOCKED  | active size matches parameters, totals repeat frame to frame
module vga_rx_monitor
   import vga_rx_pkg::*;
#(
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic               pix_clk,
   input  logic               rst_n,
   input  logic [7:0]         pix_R,
   input  logic [7:0]         pix_G,
   input  logic [7:0]         pix_B,
   input  logic               hsync,
   input  logic               vsync,
   input  logic               vid_active,
   input  logic [23:0]        match_color,
   output logic [COORD_W-1:0] meas_h_total,
   output logic [COORD_W-1:0] meas_v_total,
   output logic [COORD_W-1:0] meas_h_active,
   output logic [COORD_W-1:0] meas_v_active,
   output logic [COORD_W-1:0] bbox_x0,
   output logic [COORD_W-1:0] bbox_y0,
   output logic [COORD_W-1:0] bbox_x1,
   output logic [COORD_W-1:0] bbox_y1,
   output logic               bbox_found,
   output logic               frame_done,
   output logic               locked,
   output logic               timing_err
`ifdef VGA_RX_CHECKSUM_EN
   ,
   output logic [31:0]        frame_sum
`endif
);

   localparam logic [COORD_W-1:0] H_ACT_C = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT_C = COORD_W'(V_ACTIVE);

   rx_state_t          state;
   logic               first_pub;
   logic               hsync_q, vsync_q, va_q;
   logic               hs_edge, vs_edge, act_fall, hit;
   logic [COORD_W-1:0] h_cnt, h_tot_last, v_cnt;
   logic [COORD_W-1:0] x_cnt, y_cnt, h_act_last, cur_x, cur_y;
   logic               width_bad, line_bad;
   logic [COORD_W-1:0] fin_h_total, fin_v_active, fin_h_active;
   logic               fin_act_ok, fin_tot_ok;
   logic [COORD_W-1:0] run_x0, run_y0, run_x1, run_y1;
   logic               run_found;

   assign hs_edge  = lead_edge(hsync_q, hsync, SYNC_POL);
   assign vs_edge  = lead_edge(vsync_q, vsync, SYNC_POL);
   assign act_fall = va_q && !vid_active;
   assign hit      = vid_active && ({pix_R, pix_G, pix_B} == match_color);
   assign cur_x    = hs_edge ? '0 : x_cnt;
   assign cur_y    = vs_edge ? '0 : y_cnt;
   assign line_bad = act_fall && (x_cnt != H_ACT_C);

   // values of the frame that ends on this cycle (a simultaneous hsync edge closes its last line)
   assign fin_h_total  = hs_edge ? h_cnt : h_tot_last;
   assign fin_h_active = act_fall ? x_cnt : h_act_last;
   assign fin_v_active = sat_inc(y_cnt, act_fall);
   assign fin_act_ok   = !(width_bad || line_bad) && (fin_v_active == V_ACT_C);
   assign fin_tot_ok   = (fin_h_total == meas_h_total) && (v_cnt == meas_v_total);

   // sync history, line/frame counters and active-area coordinates
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q    <= SYNC_POL;
         vsync_q    <= SYNC_POL;
         va_q       <= 1'b0;
         h_cnt      <= '0;
         h_tot_last <= '0;
         v_cnt      <= '0;
         x_cnt      <= '0;
         y_cnt      <= '0;
         h_act_last <= '0;
         width_bad  <= 1'b0;
      end else begin
         hsync_q <= hsync;
         vsync_q <= vsync;
         va_q    <= vid_active;
         h_cnt   <= hs_edge ? 12'd1 : sat_inc(h_cnt, 1'b1);
         if (hs_edge) h_tot_last <= h_cnt;
         if (vs_edge) v_cnt <= {{(COORD_W-1){1'b0}}, hs_edge};
         else         v_cnt <= sat_inc(v_cnt, hs_edge);
         x_cnt <= sat_inc(cur_x, vid_active);
         y_cnt <= vs_edge ? '0 : sat_inc(y_cnt, act_fall);
         if (vs_edge) begin
            h_act_last <= '0;
            width_bad  <= 1'b0;
         end else begin
            if (act_fall) h_act_last <= x_cnt;
            if (line_bad) width_bad  <= 1'b1;
         end
      end
   end

   vga_rx_bbox u_bbox (
      .pix_clk     (pix_clk),
      .rst_n       (rst_n),
      .frame_start (vs_edge),
      .hit         (hit),
      .x           (cur_x),
      .y           (cur_y),
      .x0          (run_x0),
      .y0          (run_y0),
      .x1          (run_x1),
      .y1          (run_y1),
      .found       (run_found)
   );

`ifdef VGA_RX_CHECKSUM_EN
   logic [31:0] sum_acc;
   logic [31:0] pix_add;
   assign pix_add = vid_active ? {8'h00, pix_R, pix_G, pix_B} : 32'd0;

   // per-frame pixel sum; the vsync-edge pixel starts the new frame
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n)       sum_acc <= '0;
      else if (vs_edge) sum_acc <= pix_add;
      else              sum_acc <= sum_acc + pix_add;
   end
`endif

   // frame FSM: publishes the completed frame and decides lock on each vsync edge
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_SEARCH;
         first_pub     <= 1'b0;
         meas_h_total  <= '0;
         meas_v_total  <= '0;
         meas_h_active <= '0;
         meas_v_active <= '0;
         bbox_x0       <= '0;
         bbox_y0       <= '0;
         bbox_x1       <= '0;
         bbox_y1       <= '0;
         bbox_found    <= 1'b0;
         frame_done    <= 1'b0;
         locked        <= 1'b0;
         timing_err    <= 1'b0;
`ifdef VGA_RX_CHECKSUM_EN
         frame_sum     <= '0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (vs_edge) begin
            case (state)
               ST_SEARCH: begin
                  state     <= ST_MEASURE;
                  first_pub <= 1'b1;
               end
               ST_MEASURE, ST_LOCKED: begin
                  meas_h_total  <= fin_h_total;
                  meas_v_total  <= v_cnt;
                  meas_h_active <= fin_h_active;
                  meas_v_active <= fin_v_active;
                  bbox_found    <= run_found;
                  if (run_found) begin
                     bbox_x0 <= run_x0;
                     bbox_y0 <= run_y0;
                     bbox_x1 <= run_x1;
                     bbox_y1 <= run_y1;
                  end
`ifdef VGA_RX_CHECKSUM_EN
                  frame_sum <= sum_acc;
`endif
                  frame_done <= 1'b1;
                  first_pub  <= 1'b0;
                  if (fin_act_ok && fin_tot_ok) begin
                     state  <= ST_LOCKED;
                     locked <= 1'b1;
                  end else begin
                     state  <= ST_MEASURE;
                     locked <= 1'b0;
                  end
                  // the first frame after search may have started mid-line
                  if (!first_pub && !fin_act_ok) timing_err <= 1'b1;
               end
               default: begin
                  state  <= ST_SEARCH;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
